// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing (sync pulses, scan position, display_area, optional frame tick); optional tick enabled by VGA_FRAME_TICK_EN
//   ports: i_Clk pixel clock, i_Rst_n async active-low reset,
//          o_HSync/o_VSync syncs (asserted level SYNC_POL), pixel_x/pixel_y scan position,
//          display_area visible region, o_Frame_Tick one-clock pulse at start of vertical blanking
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       display_area,
  output logic       o_Frame_Tick
);
  typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_state_t;
  typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_state_t;
  h_state_t h_q, h_d;
  v_state_t v_q, v_d;
  logic [9:0] h_ph_q, h_ph_d, v_ph_q, v_ph_d, h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [9:0] h_last, v_last, pixel_x_q, pixel_y_q;
  logic h_end, h_wrap, v_end, da_q, da_d, hs_q, hs_d, vs_q, vs_d;
  always_comb begin
    h_last  = h_q == HS_ACT  ? 10'(H_ACTIVE - 1) :
              h_q == HS_FP   ? 10'(H_FRONT - 1)  :
              h_q == HS_SYNC ? 10'(H_SYNC - 1)   : 10'(H_BACK - 1);
    v_last  = v_q == VS_ACT  ? 10'(V_ACTIVE - 1) :
              v_q == VS_FP   ? 10'(V_FRONT - 1)  :
              v_q == VS_SYNC ? 10'(V_SYNC - 1)   : 10'(V_BACK - 1);
    h_end   = h_ph_q == h_last;
    h_wrap  = h_end && h_q == HS_BP;
    v_end   = h_wrap && v_ph_q == v_last;
    h_d     = h_end ? h_state_t'(h_q + 2'd1) : h_q;
    h_ph_d  = h_end ? '0 : h_ph_q + 10'd1;
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
    v_d     = v_end ? v_state_t'(v_q + 2'd1) : v_q;
    v_ph_d  = v_end ? '0 : h_wrap ? v_ph_q + 10'd1 : v_ph_q;
    v_cnt_d = v_end && v_q == VS_BP ? '0 : h_wrap ? v_cnt_q + 10'd1 : v_cnt_q;
    da_d    = h_q == HS_ACT && v_q == VS_ACT;
    hs_d    = h_q == HS_SYNC ? SYNC_POL : ~SYNC_POL;
    vs_d    = v_q == VS_SYNC ? SYNC_POL : ~SYNC_POL;
  end
  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      h_q       <= HS_ACT;
      v_q       <= VS_ACT;
      h_ph_q    <= '0;
      v_ph_q    <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      pixel_x_q <= '0;
      pixel_y_q <= '0;
      da_q      <= 1'b0;
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      h_ph_q    <= h_ph_d;
      v_ph_q    <= v_ph_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      pixel_x_q <= h_cnt_q;
      pixel_y_q <= v_cnt_q;
      da_q      <= da_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  assign pixel_x      = pixel_x_q;
  assign pixel_y      = pixel_y_q;
  assign display_area = da_q;
  assign o_HSync      = hs_q;
  assign o_VSync      = vs_q;
`ifdef VGA_FRAME_TICK_EN
  logic tick_q, tick_d;
  // first clock of the first front-porch line is column 0 of line V_ACTIVE
  always_comb tick_d = h_cnt_q == '0 && v_q == VS_FP && v_ph_q == '0;
  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) tick_q <= 1'b0;
    else          tick_q <= tick_d;
  assign o_Frame_Tick = tick_q;
`else
  assign o_Frame_Tick = 1'b0;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for vga_sync_gen using a reduced raster so whole frames fit the run
module tb_vga_sync_gen;
  localparam int HA = 20, HF = 4, HS = 6, HB = 5, VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       da;
    logic       hs;
    logic       vs;
    logic       ft;
  } obs_t;
  localparam obs_t RST_V = '{x: 10'd0, y: 10'd0, da: 1'b0, hs: 1'b1, vs: 1'b1, ft: 1'b0};
  logic clk = 1'b0, rst_n = 1'b0;
  logic hs0, vs0, da0, ft0, hs1, vs1, da1, ft1;
  logic [9:0] x0, y0, x1, y1;
  int errors = 0, checks = 0, k = 0;
  obs_t sb[$];
  vga_sync_gen #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                 .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b0)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .o_HSync(hs0), .o_VSync(vs0), .pixel_x(x0), .pixel_y(y0),
    .display_area(da0), .o_Frame_Tick(ft0));
  vga_sync_gen #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                 .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b1)) dut_pol (
    .i_Clk(clk), .i_Rst_n(rst_n), .o_HSync(hs1), .o_VSync(vs1), .pixel_x(x1), .pixel_y(y1),
    .display_area(da1), .o_Frame_Tick(ft1));
  always #5 clk = ~clk;
  function automatic obs_t model(int e);
    obs_t o;
    int x, y;
    x = (e - 1) % HT;
    y = ((e - 1) / HT) % VT;
    o.x  = 10'(x);
    o.y  = 10'(y);
    o.da = x < HA && y < VA;
    o.hs = !(x >= HA + HF && x < HA + HF + HS);
    o.vs = !(y >= VA + VF && y < VA + VF + VS);
`ifdef VGA_FRAME_TICK_EN
    o.ft = x == 0 && y == VA;
`else
    o.ft = 1'b0;
`endif
    return o;
  endfunction
  function automatic obs_t obs0();
    return '{x: x0, y: y0, da: da0, hs: hs0, vs: vs0, ft: ft0};
  endfunction
  function automatic obs_t obs1();
    return '{x: x1, y: y1, da: da1, hs: ~hs1, vs: ~vs1, ft: ft1};
  endfunction
  task automatic advance();
    sb.push_back(model(k + 1));
    @(posedge clk);
    #1;
    k++;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (obs0() !== RST_V) begin errors++; $display("FAIL reset_hold got=%h want=%h", obs0(), RST_V); end
    checks++;
    if (obs1() !== RST_V) begin errors++; $display("FAIL reset_hold_pol got=%h want=%h", obs1(), RST_V); end
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    #1;
    checks++;
    if (obs0() !== RST_V) begin errors++; $display("FAIL reset_release got=%h want=%h", obs0(), RST_V); end
  endtask
  task automatic test_line();
    obs_t e;
    int hs_n = 0;
    for (int i = 0; i < HT + 2; i++) begin
      advance();
      e = sb.pop_front();
      if (i < HT && hs0 == 1'b0) hs_n++;
      checks++;
      if (obs0() !== e) begin errors++; $display("FAIL line k=%0d got=%h want=%h", k, obs0(), e); end
      checks++;
      if (obs1() !== e) begin errors++; $display("FAIL line_pol k=%0d got=%h want=%h", k, obs1(), e); end
    end
    checks++;
    if (hs_n != HS) begin errors++; $display("FAIL hsync_width got=%0d want=%0d", hs_n, HS); end
  endtask
  task automatic test_frames();
    obs_t e;
    int vs_n = 0, ticks = 0, last_tick = -1, gap = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      advance();
      e = sb.pop_front();
      if (vs0 == 1'b0) vs_n++;
      if (ft0) begin
        ticks++;
        if (last_tick >= 0) gap = k - last_tick;
        last_tick = k;
      end
      checks++;
      if (obs0() !== e) begin errors++; $display("FAIL frame k=%0d got=%h want=%h", k, obs0(), e); end
      checks++;
      if (obs1() !== e) begin errors++; $display("FAIL frame_pol k=%0d got=%h want=%h", k, obs1(), e); end
    end
    checks++;
    if (vs_n != 2 * VS * HT) begin errors++; $display("FAIL vsync_width got=%0d want=%0d", vs_n, 2 * VS * HT); end
`ifdef VGA_FRAME_TICK_EN
    checks++;
    if (ticks != 2) begin errors++; $display("FAIL tick_count got=%0d want=2", ticks); end
    checks++;
    if (gap != HT * VT) begin errors++; $display("FAIL tick_gap got=%0d want=%0d", gap, HT * VT); end
`else
    checks++;
    if (ticks != 0) begin errors++; $display("FAIL tick_count got=%0d want=0", ticks); end
`endif
  endtask
  task automatic test_async_reset();
    obs_t e;
    int n = 0;
    e = model(k);
    while (!(e.x == 10'd10 && e.y == 10'd5) && n < HT * VT + 1) begin
      advance();
      e = sb.pop_front();
      n++;
      checks++;
      if (obs0() !== e) begin errors++; $display("FAIL pre_async k=%0d got=%h want=%h", k, obs0(), e); end
    end
    checks++;
    if (n > HT * VT) begin errors++; $display("FAIL async_target got=%0d want<=%0d", n, HT * VT); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs0() !== RST_V) begin errors++; $display("FAIL async_reset got=%h want=%h", obs0(), RST_V); end
    checks++;
    if (obs1() !== RST_V) begin errors++; $display("FAIL async_reset_pol got=%h want=%h", obs1(), RST_V); end
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 2 * HT; i++) begin
      advance();
      e = sb.pop_front();
      checks++;
      if (obs0() !== e) begin errors++; $display("FAIL restart k=%0d got=%h want=%h", k, obs0(), e); end
    end
  endtask
  initial begin
    test_reset();
    test_line();
    test_frames();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
